// File: rtl/rv32i_pkg.sv
// Shared defaults and constants for the integer register file and its scoreboard.
package rv32i_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_ZERO  = 0;

endpackage : rv32i_pkg

// File: rtl/rv32i_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, a registered pending
// count, and busy outputs masked by a same-cycle writeback when bypassing.
module rv32i_scoreboard
  import rv32i_pkg::*;
#(
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          iss_we,
  input  logic [AW-1:0] iss_addr,
  input  logic          rd_we,
  input  logic [AW-1:0] rd_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [AW:0]   pend_cnt
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             set_v, clr_v, inc, dec;
  logic             byp1, byp2;

  assign set_v = iss_we && (iss_addr != AW'(REG_ZERO));
  assign clr_v = rd_we  && (rd_addr  != AW'(REG_ZERO));

  // The count tracks actual busy-bit transitions, so a same-address
  // issue+writeback (set wins) never decrements and it always equals popcount.
  assign inc = set_v && !busy_q[iss_addr];
  assign dec = clr_v && busy_q[rd_addr] && !(set_v && (iss_addr == rd_addr));

  always_comb begin
    busy_d = busy_q;
    if (clr_v) busy_d[rd_addr]  = 1'b0;
    if (set_v) busy_d[iss_addr] = 1'b1;
    cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byp1 = (BYPASS != 0) && clr_v && (rd_addr == rs1_addr);
  assign byp2 = (BYPASS != 0) && clr_v && (rd_addr == rs2_addr);

  assign rs1_busy = busy_q[rs1_addr] && !byp1;
  assign rs2_busy = busy_q[rs2_addr] && !byp2;
  assign pend_cnt = cnt_q;

endmodule : rv32i_scoreboard

// File: rtl/rv32i_reg_file_sb.sv
// Parametrised two-read/one-write integer register file with x0 hardwired to
// zero, optional writeback-to-read bypass and an integrated busy scoreboard.
module rv32i_reg_file_sb
  import rv32i_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            iss_we,
  input  logic [AW-1:0]   iss_addr,
  input  logic            rd_we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = rd_we && (rd_addr != AW'(REG_ZERO));

  // x0 is reset and never written, so a plain array read already yields zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if ((BYPASS != 0) && wr_en && (rd_addr == rs1_addr)) rs1_data = rd_data;
    if ((BYPASS != 0) && wr_en && (rd_addr == rs2_addr)) rs2_data = rd_data;
  end

  rv32i_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .iss_we   (iss_we),
    .iss_addr (iss_addr),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .pend_cnt (pend_cnt)
  );

endmodule : rv32i_reg_file_sb

// File: tb/tb_rv32i_reg_file_sb.sv
// Bench for rv32i_reg_file_sb: bypass and non-bypass 32x32 instances share one
// stimulus stream against a reference model; a 64x16 instance is checked apart.
module tb_rv32i_reg_file_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  rs1_addr, rs2_addr, iss_addr, rd_addr;
  logic        iss_we, rd_we;
  logic [31:0] rd_data;
  logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
  logic [5:0]  a_cnt, b_cnt;

  logic [3:0]  c_rs1_addr, c_rs2_addr, c_iss_addr, c_rd_addr;
  logic        c_iss_we, c_rd_we;
  logic [63:0] c_rd_data, c_rs1_data, c_rs2_data;
  logic        c_rs1_busy, c_rs2_busy;
  logic [4:0]  c_cnt;

  rv32i_reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs1_data(a_rs1_data), .rs1_busy(a_rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(a_rs2_data), .rs2_busy(a_rs2_busy),
    .iss_we(iss_we), .iss_addr(iss_addr),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .pend_cnt(a_cnt)
  );

  rv32i_reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs1_data(b_rs1_data), .rs1_busy(b_rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(b_rs2_data), .rs2_busy(b_rs2_busy),
    .iss_we(iss_we), .iss_addr(iss_addr),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .pend_cnt(b_cnt)
  );

  rv32i_reg_file_sb #(.XLEN(64), .NREGS(16), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(c_rs1_addr), .rs1_data(c_rs1_data), .rs1_busy(c_rs1_busy),
    .rs2_addr(c_rs2_addr), .rs2_data(c_rs2_data), .rs2_busy(c_rs2_busy),
    .iss_we(c_iss_we), .iss_addr(c_iss_addr),
    .rd_we(c_rd_we), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .pend_cnt(c_cnt)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        expq_a[$];
  exp_t        expq_b[$];
  logic [63:0] expq_c[$];

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  function automatic exp_t predict(input bit byp);
    exp_t e;
    logic h1, h2;
    h1 = rd_we && (rd_addr != 0) && (rd_addr == rs1_addr);
    h2 = rd_we && (rd_addr != 0) && (rd_addr == rs2_addr);
    e.d1  = (byp && h1) ? rd_data : m_regs[rs1_addr];
    e.d2  = (byp && h2) ? rd_data : m_regs[rs2_addr];
    e.b1  = m_busy[rs1_addr] && !(byp && h1);
    e.b2  = m_busy[rs2_addr] && !(byp && h2);
    e.cnt = 6'($countones(m_busy));
    return e;
  endfunction

  task automatic model_update();
    if (rd_we && rd_addr != 0) begin
      m_regs[rd_addr] = rd_data;
      m_busy[rd_addr] = 1'b0;
    end
    if (iss_we && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic iw, input logic [4:0] ia,
                       input logic ww, input logic [4:0] wa, input logic [31:0] wd);
    rs1_addr = r1; rs2_addr = r2;
    iss_we = iw; iss_addr = ia;
    rd_we = ww; rd_addr = wa; rd_data = wd;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic cycle(input string tag);
    exp_t ea, eb;
    expq_a.push_back(predict(1'b1));
    expq_b.push_back(predict(1'b0));
    @(negedge clk);
    ea = expq_a.pop_front();
    eb = expq_b.pop_front();
    chk({tag, ".byp.rs1_data"}, a_rs1_data, ea.d1);
    chk({tag, ".byp.rs2_data"}, a_rs2_data, ea.d2);
    chk({tag, ".byp.rs1_busy"}, a_rs1_busy, ea.b1);
    chk({tag, ".byp.rs2_busy"}, a_rs2_busy, ea.b2);
    chk({tag, ".byp.pend_cnt"}, a_cnt, ea.cnt);
    chk({tag, ".nob.rs1_data"}, b_rs1_data, eb.d1);
    chk({tag, ".nob.rs2_data"}, b_rs2_data, eb.d2);
    chk({tag, ".nob.rs1_busy"}, b_rs1_busy, eb.b1);
    chk({tag, ".nob.rs2_busy"}, b_rs2_busy, eb.b2);
    chk({tag, ".nob.pend_cnt"}, b_cnt, eb.cnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic c_check(input string tag, input logic [63:0] obs);
    chk(tag, obs, expq_c.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    c_rs1_addr = '0; c_rs2_addr = '0; c_iss_we = 1'b0; c_iss_addr = '0;
    c_rd_we = 1'b0; c_rd_addr = '0; c_rd_data = '0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    drive(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);          cycle("after_reset");
    drive(5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0);          cycle("issue_x5");
    drive(5'd5, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);   cycle("wb_x5");
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0);          cycle("read_x5");
    drive(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    // Asynchronous reset between edges: outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.byp.rs1_data", a_rs1_data, 64'h0);
    chk("async_rst.nob.rs1_data", b_rs1_data, 64'h0);
    chk("async_rst.byp.rs1_busy", a_rs1_busy, 64'h0);
    chk("async_rst.byp.pend_cnt", a_cnt, 64'h0);
    chk("async_rst.nob.pend_cnt", b_cnt, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    drive(5'd0, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);   cycle("x0_wr_iss");
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);          cycle("x0_read");
    drive(5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);          cycle("issue_x3");
    drive(5'd3, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);          cycle("issue_x4");
    drive(5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);          cycle("two_pending");
    drive(5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 5'd3, 32'h00000333);   cycle("wb_x3");
    drive(5'd3, 5'd4, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);          cycle("issue_x7");
    drive(5'd3, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678);   cycle("bypass_x7");
    drive(5'd7, 5'd7, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);          cycle("issue_x9");
    drive(5'd9, 5'd4, 1'b1, 5'd9, 1'b1, 5'd9, 32'hA5A5A5A5);   cycle("collide_x9");
    drive(5'd9, 5'd4, 1'b1, 5'd4, 1'b1, 5'd10, 32'h0000AAAA);  cycle("reissue_x4_wb_x10");
    drive(5'd9, 5'd10, 1'b1, 5'd11, 1'b1, 5'd4, 32'h44444444); cycle("diff_set_clr");
    drive(5'd9, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);          cycle("settle");

    for (int n = 0; n < 48; n++) begin
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      cycle("random");
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

    // 64-bit / 16-entry instance.
    c_rd_we = 1'b1; c_rd_addr = 4'd15; c_rd_data = 64'h0123456789ABCDEF;
    c_rs1_addr = 4'd15; c_rs2_addr = 4'd0;
    expq_c.push_back(64'h0123456789ABCDEF);
    expq_c.push_back(64'h0);
    @(negedge clk);
    c_check("w64.bypass_rs1", c_rs1_data);
    c_check("w64.x0_rs2", c_rs2_data);
    @(posedge clk); #1;
    c_rd_we = 1'b0; c_rs2_addr = 4'd15;
    expq_c.push_back(64'h0123456789ABCDEF);
    expq_c.push_back(64'h0123456789ABCDEF);
    @(negedge clk);
    c_check("w64.stored_rs1", c_rs1_data);
    c_check("w64.stored_rs2", c_rs2_data);
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      c_iss_we = 1'b1; c_iss_addr = 4'(r);
      @(posedge clk); #1;
    end
    c_iss_we = 1'b0; c_rs1_addr = 4'd15; c_rs2_addr = 4'd0;
    expq_c.push_back(64'd15);
    expq_c.push_back(64'd1);
    expq_c.push_back(64'd0);
    @(negedge clk);
    c_check("w64.pend_all", c_cnt);
    c_check("w64.busy_x15", c_rs1_busy);
    c_check("w64.busy_x0", c_rs2_busy);
    @(posedge clk); #1;
    c_rd_we = 1'b1; c_rd_addr = 4'd15; c_rd_data = 64'hFEDCBA9876543210;
    @(posedge clk); #1;
    c_rd_we = 1'b0;
    expq_c.push_back(64'd14);
    expq_c.push_back(64'd0);
    expq_c.push_back(64'hFEDCBA9876543210);
    @(negedge clk);
    c_check("w64.pend_after_wb", c_cnt);
    c_check("w64.busy_x15_clr", c_rs1_busy);
    c_check("w64.data_x15", c_rs1_data);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_rv32i_reg_file_sb
